// File: rtl/ps2_mouse_pkg.sv
// Shared constants, state encoding and default timing values for the PS/2 mouse controller.
package ps2_mouse_pkg;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_STREAM = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_BAT    = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    localparam int DEF_RESP_TIMEOUT = 25_000_000;
    localparam int DEF_PKT_GAP      = 1_000_000;
    localparam int DEF_MAX_RETRY    = 3;
    localparam int DEF_TMR_W        = 25;

    typedef enum logic [3:0] {
        RST_SEND = 4'd0,
        RST_TX   = 4'd1,
        RST_ACK  = 4'd2,
        RST_BAT  = 4'd3,
        RST_ID   = 4'd4,
        EN_SEND  = 4'd5,
        EN_TX    = 4'd6,
        EN_ACK   = 4'd7,
        PKT1     = 4'd8,
        PKT2     = 4'd9,
        PKT3     = 4'd10,
        FAIL     = 4'd11
    } state_e;

    // The timer runs while waiting on the mouse during init and between packet bytes.
    function automatic logic timer_runs(input state_e s);
        logic r;
        case (s)
            RST_TX, RST_ACK, RST_BAT, RST_ID,
            EN_SEND, EN_TX, EN_ACK, PKT2, PKT3: r = (s != EN_SEND);
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_mouse_if.sv
// Byte-level handshake between the mouse controller and the PS/2 rx/tx datapath.
interface ps2_mouse_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_done_tick;
    logic       rx_done_tick;
    logic [7:0] dout;

    modport master (output wr_ps2, din, input tx_done_tick, rx_done_tick, dout);
    modport slave  (input wr_ps2, din, output tx_done_tick, rx_done_tick, dout);
endinterface

// File: rtl/ps2_mouse_timer.sv
// Shared response/packet-gap timer: clear wins over enable; terminal counts compare the live count.
module ps2_mouse_timer #(
    parameter int TMR_W        = 25,
    parameter int RESP_TIMEOUT = 25_000_000,
    parameter int PKT_GAP      = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic resp_tc,
    output logic gap_tc
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    // Next count: clear, increment or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {TMR_W{1'b0}};
        end else if (en) begin
            count_d = count_q + {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= {TMR_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign resp_tc = (count_q == TMR_W'(RESP_TIMEOUT - 1));
    assign gap_tc  = (count_q == TMR_W'(PKT_GAP - 1));

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse sequencer: reset/enable handshake with retries, then 3-byte movement packet assembly.
module ps2_mouse_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT,
    parameter int PKT_GAP      = DEF_PKT_GAP,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int TMR_W        = DEF_TMR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    ps2_mouse_if.master       bus,
    output logic [8:0]        xm,
    output logic [8:0]        ym,
    output logic [2:0]        btnm,
    output logic              m_done_tick,
    output logic              init_done,
    output logic              err
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    state_e             state_q, state_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [RETRY_W-1:0] retry_inc_s;
    logic [4:0]         b1_q, b1_d;      // {y sign, x sign, middle, right, left}
    logic [7:0]         b2_q, b2_d;
    logic [8:0]         xm_q, xm_d;
    logic [8:0]         ym_q, ym_d;
    logic [2:0]         btn_q, btn_d;
    logic               mdone_q, mdone_d;
    logic               init_done_q, init_done_d;
    logic               err_q, err_d;
    logic               wr_q, wr_d;
    logic [7:0]         din_q, din_d;
    logic               fail_s;
    logic               tmr_clr_s;
    logic               tmr_en_s;
    logic               resp_tc_s;
    logic               gap_tc_s;

    logic       rx_s;
    logic       tx_s;
    logic [7:0] rx_byte_s;

    assign rx_s      = bus.rx_done_tick;
    assign tx_s      = bus.tx_done_tick;
    assign rx_byte_s = bus.dout;

    ps2_mouse_timer #(
        .TMR_W        (TMR_W),
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .PKT_GAP      (PKT_GAP)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmr_clr_s),
        .en      (tmr_en_s),
        .resp_tc (resp_tc_s),
        .gap_tc  (gap_tc_s)
    );

    // Next-state, retry bookkeeping and registered-output computation.
    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        xm_d        = xm_q;
        ym_d        = ym_q;
        btn_d       = btn_q;
        mdone_d     = 1'b0;
        init_done_d = init_done_q;
        wr_d        = 1'b0;
        din_d       = din_q;
        fail_s      = 1'b0;
        retry_inc_s = retry_q + RETRY_W'(1);

        case (state_q)
            RST_SEND: begin
                wr_d    = 1'b1;
                din_d   = CMD_RESET;
                state_d = RST_TX;
            end
            EN_SEND: begin
                wr_d    = 1'b1;
                din_d   = CMD_STREAM;
                state_d = EN_TX;
            end
            RST_TX, EN_TX: begin
                // Any byte arriving before our command has gone out means the link is confused.
                if (rx_s) begin
                    fail_s = 1'b1;
                end else if (tx_s) begin
                    state_d = (state_q == RST_TX) ? RST_ACK : EN_ACK;
                end else if (resp_tc_s) begin
                    fail_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            RST_ACK: begin
                if (rx_s) begin
                    if (rx_byte_s == RSP_ACK) state_d = RST_BAT;
                    else                      fail_s  = 1'b1;
                end else if (resp_tc_s) begin
                    fail_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            RST_BAT: begin
                if (rx_s) begin
                    if (rx_byte_s == RSP_BAT) state_d = RST_ID;
                    else                      fail_s  = 1'b1;
                end else if (resp_tc_s) begin
                    fail_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            RST_ID: begin
                if (rx_s) begin
                    if (rx_byte_s == RSP_ID) state_d = EN_SEND;
                    else                     fail_s  = 1'b1;
                end else if (resp_tc_s) begin
                    fail_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            EN_ACK: begin
                if (rx_s) begin
                    if (rx_byte_s == RSP_ACK) begin
                        state_d     = PKT1;
                        retry_d     = {RETRY_W{1'b0}};
                        init_done_d = 1'b1;
                    end else begin
                        fail_s = 1'b1;
                    end
                end else if (resp_tc_s) begin
                    fail_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            PKT1: begin
                // Only a byte with the always-one bit set can start a packet.
                if (rx_s && rx_byte_s[3]) begin
                    b1_d    = {rx_byte_s[5], rx_byte_s[4], rx_byte_s[2:0]};
                    state_d = PKT2;
                end else begin
                    state_d = PKT1;
                end
            end
            PKT2: begin
                if (rx_s) begin
                    b2_d    = rx_byte_s;
                    state_d = PKT3;
                end else if (gap_tc_s) begin
                    state_d = PKT1;
                end else begin
                    state_d = PKT2;
                end
            end
            PKT3: begin
                if (rx_s) begin
                    xm_d    = {b1_q[3], b2_q};
                    ym_d    = {b1_q[4], rx_byte_s};
                    btn_d   = b1_q[2:0];
                    mdone_d = 1'b1;
                    state_d = PKT1;
                end else if (gap_tc_s) begin
                    state_d = PKT1;
                end else begin
                    state_d = PKT3;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = RST_SEND;
            end
        endcase

        if (fail_s) begin
            retry_d = retry_inc_s;
            state_d = (retry_inc_s == RETRY_W'(MAX_RETRY)) ? FAIL : RST_SEND;
        end else begin
            retry_d = retry_d;
        end

        err_d     = err_q | (state_d == FAIL);
        tmr_clr_s = (state_d != state_q) | rx_s;
        tmr_en_s  = timer_runs(state_q);
    end

    // State, packet and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RST_SEND;
            retry_q     <= {RETRY_W{1'b0}};
            b1_q        <= 5'd0;
            b2_q        <= 8'h00;
            xm_q        <= 9'd0;
            ym_q        <= 9'd0;
            btn_q       <= 3'd0;
            mdone_q     <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            wr_q        <= 1'b0;
            din_q       <= CMD_RESET;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            xm_q        <= xm_d;
            ym_q        <= ym_d;
            btn_q       <= btn_d;
            mdone_q     <= mdone_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            wr_q        <= wr_d;
            din_q       <= din_d;
        end
    end

    assign bus.wr_ps2  = wr_q;
    assign bus.din     = din_q;
    assign xm          = xm_q;
    assign ym          = ym_q;
    assign btnm        = btn_q;
    assign m_done_tick = mdone_q;
    assign init_done   = init_done_q;
    assign err         = err_q;

endmodule

// File: doc/ps2_mouse_ctrl.md
Name: ps2_mouse_ctrl

Overview:
Sequences the PS/2 rx/tx datapath for a PS/2 mouse. After reset it sends the init commands: reset 0xFF, then enable-streaming 0xF4. It checks every mouse response and retries on failure. In streaming mode it assembles 3-byte movement packets into signed X/Y deltas and button state for the downstream cursor/display logic.

Parameters:
RESP_TIMEOUT, 25_000_000, max clk cycles to wait for tx_done_tick or any expected response byte (0.5 s at 50 MHz)
PKT_GAP, 1_000_000, max clk cycles between bytes of one movement packet before resync (20 ms)
MAX_RETRY, 3, init attempts before err asserts
TMR_W, 25, timer counter width; must hold max(RESP_TIMEOUT, PKT_GAP)

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
wr_ps2  out  1  one-cycle request to transmit din
din  out  8  command byte to transmit
tx_done_tick  in  1  transmit complete
rx_done_tick  in  1  byte received, dout valid this cycle
dout  in  8  received byte
xm  out  9  X delta, two's complement {sign, byte2}
ym  out  9  Y delta, two's complement {sign, byte3}
btnm  out  3  {middle, right, left} buttons
m_done_tick  out  1  one-cycle pulse: new packet on xm/ym/btnm
init_done  out  1  high once streaming is enabled
err  out  1  sticky: init failed MAX_RETRY times

Behaviour:
- Reset (reset_n low, asynchronous):
  - state RST_SEND; retry count 0; timer 0.
  - wr_ps2=0, din=0xFF, xm=0, ym=0, btnm=0, m_done_tick=0, init_done=0, err=0.
- Deassertion is used as-is; the synchroniser is upstream.
- FSM states and transitions:
  - RST_SEND: wr_ps2=1 for exactly one cycle with din=0xFF -> RST_TX.
  - RST_TX: wait tx_done_tick -> RST_ACK.
  - RST_ACK: expect 0xFA -> RST_BAT.
  - RST_BAT: expect 0xAA -> RST_ID.
  - RST_ID: expect 0x00 -> EN_SEND.
  - EN_SEND: wr_ps2=1 for one cycle with din=0xF4 -> EN_TX.
  - EN_TX: wait tx_done_tick -> EN_ACK.
  - EN_ACK: expect 0xFA -> PKT1; init_done goes high the cycle PKT1 is entered and stays high.
  - PKT1 -> PKT2 -> PKT3 -> PKT1.
  - FAIL: terminal; err=1; ignores all inputs until reset.
- din holds its value from the send cycle until the next send.
- Timer behaviour:
  - Clears on every state change and on every rx_done_tick.
  - Counts in RST_TX..EN_ACK and PKT2/PKT3.
  - Never counts in PKT1.
- Init failure conditions, all in RST_TX..EN_ACK:
  - wrong byte on rx_done_tick;
  - timer reaching RESP_TIMEOUT-1;
  - rx_done_tick in RST_TX or EN_TX.
- On init failure:
  - retry count +1.
  - If the new count equals MAX_RETRY -> FAIL.
  - Otherwise -> RST_SEND.
- Retry count clears on entry to PKT1.
- Packet framing:
  - PKT1 accepts byte1 only if bit3=1. Otherwise the byte is discarded and the state stays PKT1 (resync).
  - PKT2 stores byte2 -> PKT3.
  - PKT2 or PKT3 timer reaching PKT_GAP-1 -> PKT1, partial packet dropped, no output change.
- Output timing:
  - On rx_done_tick in PKT3, at the same clock edge: xm={b1[4],b2}, ym={b1[5],b3}, btnm=b1[2:0], and m_done_tick is registered high.
  - m_done_tick is high for exactly the next cycle, with the new values already stable.
  - xm/ym/btnm hold until the next complete packet.
  - Overflow bits b1[7:6] are ignored; deltas are passed unsaturated.
- Simultaneous events:
  - rx_done_tick and timer expiry in the same cycle: the byte wins; the timer is cleared.
  - tx_done_tick outside RST_TX/EN_TX is ignored.
- Unsolicited 0xAA 0x00 during streaming (mouse hot-replug) is not detected. It is treated as framing: 0xAA has bit3=1, so it is taken as byte1. The resulting bogus packet is accepted (known limitation).

Decomposition:
- Shared package ps2_mouse_pkg holds:
  - command/response constants: CMD_RESET=0xFF, CMD_STREAM=0xF4, RSP_ACK=0xFA, RSP_BAT=0xAA, RSP_ID=0x00;
  - FSM state encoding;
  - default timeout values.
- One natural sub-module, ps2_mouse_timer: TMR_W-bit up-counter with synchronous clear and enable inputs, and terminal-count compare outputs for RESP_TIMEOUT and PKT_GAP.
- The FSM, retry counter and packet registers stay in the top.

Test Plan:
- Clean init:
  - Release reset_n; stimulus: tx_done_tick, then rx FA, AA, 00; tx_done_tick; rx FA.
  - Required: exactly two wr_ps2 pulses, din=0xFF then 0xF4; init_done=1; err=0.
- Packet assembly:
  - After init, rx 0x39, 0x05, 0xFB.
  - Required: xm=0x105 (-251), ym=0x1FB (-5), btnm=3'b001, one m_done_tick the cycle after byte3.
- Resync:
  - After init, rx 0x05 (bit3=0), then 0x08, 0x10, 0x20.
  - Required: 0x05 is dropped; one packet with xm=0x010, ym=0x020, btnm=0; exactly one m_done_tick.
- Packet gap:
  - Rx 0x08, 0x01, then idle PKT_GAP cycles (reduced parameters in the bench), then 0x08, 0x02, 0x03.
  - Required: only the second packet reported, xm=0x002, ym=0x003.
- Init retry/fail:
  - Answer 0xFC instead of 0xFA three times, with MAX_RETRY=3.
  - Required: three 0xFF sends, then err=1, init_done=0, no further wr_ps2.
  - With no response at all and RESP_TIMEOUT=100: same result after the timeouts.
- Reset mid-packet:
  - Assert reset_n low after byte2 of a packet.
  - Required: all outputs 0 immediately (asynchronous), FSM restarts and issues 0xFF again.
